// File: rtl/tl_pkg.sv
// tl_pkg: state encodings, lamp codes and phase lookup for the traffic phase sequencer
package tl_pkg;
  localparam logic [3:0] S_AG  = 4'd0, S_AY  = 4'd1, S_ALG = 4'd2, S_ALY = 4'd3;
  localparam logic [3:0] S_BG  = 4'd4, S_BY  = 4'd5, S_BLG = 4'd6, S_BLY = 4'd7;
  localparam logic [3:0] S_PED = 4'd8;
  localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10;
  // phase index 0..3 = A, AL, B, BL greens; 4 = pedestrian walk
  function automatic logic [3:0] green_of(input logic [2:0] i);
    return i == 3'd4 ? S_PED : {1'b0, i[1:0], 1'b0};
  endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: per-state cycle counter, cleared on state change, saturating at all-ones
module tl_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  output logic [TW-1:0] cnt_o
);
  logic [TW-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : cnt_q + TW'(!(&cnt_q));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/tl_phase_sequencer.sv
// tl_phase_sequencer: four-phase traffic sequencer with min/max green, fixed yellow,
// an all-red pedestrian walk phase and demand-driven phase skipping
module tl_phase_sequencer
  import tl_pkg::*;
#(
  parameter int TW        = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lal,
  output logic [1:0] Lb,
  output logic [1:0] Lbl,
  output logic       ped_walk,
  output logic [3:0] state
);
  localparam logic [TW-1:0] MIN_C  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_C  = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_C  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] WALK_C = TW'(WALK_T - 1);
  logic [3:0]      state_q, state_d;
  logic            ped_pend_q, ped_pend_d;
  logic [TW-1:0]   tmr;
  logic [4:0]      dem;
  logic [1:0]      ph;
  logic            go;
  logic [3:0][1:0] lamp;
  assign dem = {ped_pend_q, Tbl, Tb, Tal, Ta};
  assign ph  = state_q[2:1];
  // scan downward so the phase closest after p is the last (winning) assignment
  function automatic logic [3:0] next_green(input logic [2:0] p, input logic [4:0] d);
    logic [3:0] i;
    next_green = p < 3'd2 ? S_BG : S_AG;
    for (int k = 4; k >= 1; k--) begin
      i = {1'b0, p} + 4'(k);
      i = i >= 4'd5 ? i - 4'd5 : i;
      if (d[i[2:0]]) next_green = green_of(i[2:0]);
    end
  endfunction
  always_comb begin
    go = tmr >= MIN_C && |(dem & ~(5'd1 << ph)) && (!dem[{1'b0, ph}] || tmr >= MAX_C);
    state_d = state_q > S_PED  ? S_AG
            : state_q == S_PED ? (tmr == WALK_C ? next_green(3'd4, dem) : S_PED)
            : state_q[0]       ? (tmr == YEL_C ? next_green({1'b0, ph}, dem) : state_q)
            : go               ? state_q | 4'd1 : state_q;
    ped_pend_d = state_d == S_PED && state_q != S_PED ? 1'b0
               : ped_pend_q | (ped_req && state_q != S_PED);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= S_AG;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
    end
  tl_phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (state_d != state_q),
    .cnt_o  (tmr)
  );
  always_comb begin
    lamp = {4{RED}};
    if (state_q < S_PED) lamp[ph] = state_q[0] ? YELLOW : GREEN;
  end
  assign {Lbl, Lb, Lal, La} = lamp;
  assign ped_walk = state_q == S_PED;
  assign state    = state_q;
endmodule

// File: tb/tb_tl_phase_sequencer.sv
// tb_tl_phase_sequencer: table vectors, directed corner sequences and random traffic
// checked cycle by cycle against a phase-level reference model
module tb_tl_phase_sequencer;
  localparam int MIN_G = 4, MAX_G = 10, YEL = 2, WALK = 3;
  localparam logic [8:0] O_AG = 9'b00_10_10_10_0, O_AY = 9'b01_10_10_10_0;
  localparam logic [8:0] O_BG = 9'b10_10_00_10_0;
  logic clk = 0, reset_n = 0;
  logic Ta = 0, Tal = 0, Tb = 0, Tbl = 0, ped_req = 0;
  logic [1:0] La, Lal, Lb, Lbl;
  logic ped_walk;
  logic [3:0] state;
  logic [8:0] outs;
  int n_chk = 0, n_pass = 0;
  int m_ph, m_t;
  bit m_y, m_pend;
  typedef struct packed { logic [4:0] in; logic [8:0] exp; } vec_t;
  vec_t tbl[7];

  tl_phase_sequencer #(.TW(8), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL), .WALK_T(WALK)) dut (
    .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl), .ped_req(ped_req),
    .La(La), .Lal(Lal), .Lb(Lb), .Lbl(Lbl), .ped_walk(ped_walk), .state(state));

  always #5 clk = ~clk;
  assign outs = {La, Lal, Lb, Lbl, ped_walk};

  // model phase: 0 A, 1 AL, 2 B, 3 BL, 4 PED; m_y marks the yellow of phases 0..3
  function automatic logic [8:0] m_out();
    logic [8:0] o;
    o[0] = m_ph == 4;
    for (int i = 0; i < 4; i++) o[8-2*i -: 2] = m_ph != i ? 2'b10 : m_y ? 2'b01 : 2'b00;
    return o;
  endfunction

  function automatic int next_ph(input int p, input bit d[5]);
    for (int k = 1; k < 5; k++) if (d[(p + k) % 5]) return (p + k) % 5;
    return p < 2 ? 2 : 0;
  endfunction

  task automatic model_step();
    bit d[5];
    bit oth, ny;
    int np;
    d = '{Ta, Tal, Tb, Tbl, m_pend};
    np = m_ph;
    ny = m_y;
    oth = 0;
    for (int j = 0; j < 5; j++) if (j != m_ph && d[j]) oth = 1;
    if (m_ph == 4) begin
      if (m_t == WALK - 1) np = next_ph(4, d);
    end else if (m_y) begin
      if (m_t == YEL - 1) begin np = next_ph(m_ph, d); ny = 0; end
    end else if (m_t >= MIN_G - 1 && oth && (!d[m_ph] || m_t >= MAX_G - 1)) ny = 1;
    if (np == 4 && m_ph != 4) m_pend = 0;
    else if (m_ph != 4 && ped_req) m_pend = 1;
    m_t = (np != m_ph || ny != m_y) ? 0 : (m_t < 255 ? m_t + 1 : 255);
    m_ph = np;
    m_y = ny;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: lamps/walk got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic cyc(input string name);
    @(posedge clk);
    model_step();
    #1 check(name, outs, m_out());
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    m_ph = 0; m_y = 0; m_t = 0; m_pend = 0;
    #1 check("reset", outs, O_AG);
    @(negedge clk) reset_n = 1;
  endtask

  task automatic set_in(input logic a, input logic al, input logic b, input logic bl);
    {Ta, Tal, Tb, Tbl} = {a, al, b, bl};
  endtask

  initial begin
    int cnt;
    bit seen;
    // 1: only A demand keeps AG forever
    set_in(1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 50; i++) cyc("t1_hold_ag");
    // 2: table of A -> B handover
    for (int i = 0; i < 7; i++)
      tbl[i] = '{in: 5'b00100, exp: i < 3 ? O_AG : i < 5 ? O_AY : O_BG};
    set_in(0, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      {Ta, Tal, Tb, Tbl, ped_req} = tbl[i].in;
      @(posedge clk);
      model_step();
      #1 check("t2_table", outs, tbl[i].exp);
    end
    // 3: contested green runs to max, AL skipped
    set_in(1, 0, 1, 0);
    do_reset();
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      cyc("t3_seq");
      if (La == 2'b00) cnt++;
      else break;
    end
    check_int("t3_ag_len", cnt, MAX_G);
    for (int i = 0; i < 3; i++) cyc("t3_to_bg");
    check_int("t3_bg_lamp", int'(Lb), 0);
    // 4: pedestrian request from BG, fallback to AG
    set_in(0, 0, 0, 0);
    ped_req = 1;
    cyc("t4_req");
    ped_req = 0;
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc("t4_seq");
      if (ped_walk) begin cnt++; seen = 1; end
      else if (seen) break;
    end
    check_int("t4_walk_len", cnt, WALK);
    check_int("t4_fallback_ag", int'(La), 0);
    // 5: AL demand appearing during AY, then dropped after 6 AL-green cycles
    set_in(0, 0, 1, 0);
    for (int i = 0; i < 20 && La != 2'b01; i++) cyc("t5_to_ay");
    check_int("t5_in_ay", int'(La), 1);
    set_in(0, 1, 1, 0);
    for (int i = 0; i < 10 && Lal != 2'b00; i++) cyc("t5_to_alg");
    check_int("t5_in_alg", int'(Lal), 0);
    for (int i = 0; i < 5; i++) cyc("t5_alg");
    set_in(0, 0, 1, 0);
    cyc("t5_aly");
    check_int("t5_aly_lamp", int'(Lal), 1);
    for (int i = 0; i < 3; i++) cyc("t5_to_bg");
    // 6: reset in the middle of BY with a pending walk request
    set_in(0, 0, 0, 0);
    ped_req = 1;
    cyc("t6_req");
    ped_req = 0;
    for (int i = 0; i < 20 && Lb != 2'b01; i++) cyc("t6_to_by");
    check_int("t6_in_by", int'(Lb), 1);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("t6_after");
      if (ped_walk) cnt++;
    end
    check_int("t6_no_walk", cnt, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) Ta = ~Ta;
      if ($urandom_range(0, 7) == 0) Tal = ~Tal;
      if ($urandom_range(0, 7) == 0) Tb = ~Tb;
      if ($urandom_range(0, 7) == 0) Tbl = ~Tbl;
      ped_req = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
